// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-split helpers for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int LINES     = 32;
  localparam int LINE_BITS = 256;
  localparam int ADDR_W    = 32;
  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = $clog2(LINES);
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W    = OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:INDEX_W+OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:2];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: one combinational read port, one line-or-word write port.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   rd_idx_i,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [LINE_BITS-1:0] rd_line_o,
  input  logic [INDEX_W-1:0]   wr_idx_i,
  input  logic                 line_we_i,
  input  logic [TAG_W-1:0]     line_tag_i,
  input  logic [LINE_BITS-1:0] line_data_i,
  input  logic                 word_we_i,
  input  logic [WORD_W-1:0]    word_sel_i,
  input  logic [31:0]          word_data_i
);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Only the status bits are reset; tags and data are meaningless while valid is clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= line_tag_i;
      data_q[wr_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller with miss stall and line refill.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  state_e               state_q, state_d;
  logic                 req, is_store, hit;
  logic [TAG_W-1:0]     req_tag, vic_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [WORD_W-1:0]    req_word;
  logic                 vic_valid, vic_dirty;
  logic [LINE_BITS-1:0] vic_line;
  logic                 line_we, word_we;

  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_store = cpu_MemWrite_i;
  assign req_tag  = addr_tag(cpu_addr_i);
  assign req_idx  = addr_idx(cpu_addr_i);
  assign req_word = addr_word(cpu_addr_i);
  assign hit      = vic_valid & (vic_tag == req_tag);

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (req_idx),
    .rd_tag_o    (vic_tag),
    .rd_valid_o  (vic_valid),
    .rd_dirty_o  (vic_dirty),
    .rd_line_o   (vic_line),
    .wr_idx_i    (req_idx),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag),
    .line_data_i (mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (req_word),
    .word_data_i (cpu_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The CPU holds its request while stalled, so the victim read port stays stable through a miss.
  always_comb begin
    state_d      = state_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_data_o = vic_line[{req_word, 5'b0} +: 32];
            word_we    = is_store;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (vic_valid & vic_dirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {vic_tag, req_idx, {OFFSET_W{1'b0}}};
        mem_data_o   = vic_line;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset drops any in-flight memory request in the same cycle and blocks array writes.
    if (rst_i) begin
      cpu_data_o   = '0;
      cpu_stall_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      line_we      = 1'b0;
      word_we      = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign hit_cnt_d  = hit_cnt_q  + {31'b0, (state_q == IDLE) & req & hit};
  assign miss_cnt_d = miss_cnt_q + {31'b0, (state_q == IDLE) & req & ~hit};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, reset/spurious-ack sequences, random traffic.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [31:0]          cpu_addr_i, cpu_data_i;
  logic                 cpu_MemRead_i, cpu_MemWrite_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic [31:0]          mem_addr_o;
  logic [255:0]         mem_data_o;
  logic                 mem_enable_o, mem_write_o;
  logic [255:0]         mem_data_i;
  logic                 mem_ack_i;
  logic [31:0]          hit_cnt_o, miss_cnt_o;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Backing memory image plus a word-level golden overlay for stores not yet written back.
  logic [255:0] backing [logic [31:0]];
  logic [31:0]  gold    [logic [31:0]];

  // Memory responder state and per-access observations.
  int          dwb = 1, drf = 1, cnt = 0, en_cycles = 0;
  bit          prev_en = 1'b0;
  logic [31:0] prev_addr;
  logic        prev_wr;
  logic [31:0] last_wb_addr, last_wb_w0, last_rf_addr, rf_hit_cnt, rf_miss_cnt;
  logic        s_stall;
  logic [31:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] la, input int w);
    return 32'hA000_0000 + (la << 4) + w;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la, w);
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [255:0] l;
    if (gold.exists(a)) return gold[a];
    l = mem_line({a[31:5], 5'b0});
    return l[{a[4:2], 5'b0} +: 32];
  endfunction

  // One clock: sample outputs after inputs settle, act as memory, then advance to the next negedge.
  task automatic tick();
    #1;
    s_stall   = cpu_stall_o;
    s_data    = cpu_data_o;
    mem_ack_i = 1'b0;
    if (mem_enable_o) begin
      en_cycles++;
      if (prev_en) begin
        check("mem_addr_stable", mem_addr_o, prev_addr);
        check("mem_write_stable", {31'b0, mem_write_o}, {31'b0, prev_wr});
      end
      if (mem_write_o) last_wb_addr = mem_addr_o;
      else if (cnt == 0) begin
        last_rf_addr = mem_addr_o;
        rf_hit_cnt   = hit_cnt_o;
        rf_miss_cnt  = miss_cnt_o;
      end
      cnt++;
      if (cnt >= (mem_write_o ? dwb : drf)) begin
        mem_ack_i = 1'b1;
        cnt       = 0;
        prev_en   = 1'b0;
        if (mem_write_o) begin
          backing[mem_addr_o] = mem_data_o;
          last_wb_w0          = mem_data_o[31:0];
        end else begin
          mem_data_i = mem_line(mem_addr_o);
        end
      end else begin
        prev_en   = 1'b1;
        prev_addr = mem_addr_o;
        prev_wr   = mem_write_o;
      end
    end else begin
      cnt     = 0;
      prev_en = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int w_dly, input int r_dly, output int stalls, output logic [31:0] rdata);
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_addr_i     = a;
    cpu_data_i     = d;
    dwb = w_dly;
    drf = r_dly;
    stalls = 0;
    en_cycles = 0;
    rdata = '0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (!s_stall) begin
        rdata = s_data;
        break;
      end
      stalls++;
    end
    if (stalls >= 300) begin
      total++;
      bad++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles", a, stalls);
    end
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          dw;
    int          dr;
    int          exp_stall;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl [4];
  int          st;
  logic [31:0] rd_v;
  logic [31:0] exp_h, exp_m;

  // Random-phase reference state: which line each index holds.
  logic [31:0] mline [32];
  bit          mval  [32];
  bit          mdirty[32];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("reset_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("reset_enable", {31'b0, mem_enable_o}, 32'd0);
    check("reset_write", {31'b0, mem_write_o}, 32'd0);
    check("reset_mem_addr", mem_addr_o, 32'd0);
    check("reset_cpu_data", cpu_data_o, 32'd0);
    check("reset_hit_cnt", hit_cnt_o, 32'd0);
    check("reset_miss_cnt", miss_cnt_o, 32'd0);

    // Cold load, neighbour hit, store hit, conflicting load evicting the dirty line.
    tbl[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        1, 3, 5, init_word(32'h40, 0)};
    tbl[1] = '{1'b1, 1'b0, 32'h44,  32'h0,        1, 1, 0, init_word(32'h40, 1)};
    tbl[2] = '{1'b0, 1'b1, 32'h40,  32'hDEADBEEF, 1, 1, 0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h440, 32'h0,        2, 2, 6, init_word(32'h440, 0)};
    for (int i = 0; i < 4; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].dw, tbl[i].dr, st, rd_v);
      check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
      if (tbl[i].rd && !tbl[i].wr) check($sformatf("vec%0d_data", i), rd_v, tbl[i].exp_data);
      if (tbl[i].exp_stall == 0) check($sformatf("vec%0d_no_mem", i), en_cycles, 32'd0);
      else check($sformatf("vec%0d_refill_addr", i), last_rf_addr, {tbl[i].addr[31:5], 5'b0});
    end
    check("evict_wb_addr", last_wb_addr, 32'h40);
    check("evict_wb_word0", last_wb_w0, 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
    exp_h = 32'd3; exp_m = 32'd2;
`else
    exp_h = 32'd0; exp_m = 32'd0;
`endif
    check("stats_hit_cnt", rf_hit_cnt, exp_h);
    check("stats_miss_cnt", rf_miss_cnt, exp_m);

    // Spurious ack in IDLE must not touch the array.
    mem_data_i = {8{32'hBAD0BAD0}};
    mem_ack_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("spurious_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("spurious_enable", {31'b0, mem_enable_o}, 32'd0);
    access(1'b1, 1'b0, 32'h440, 32'h0, 1, 1, st, rd_v);
    check("spurious_hit_stall", st, 32'd0);
    check("spurious_hit_data", rd_v, init_word(32'h440, 0));
    access(1'b1, 1'b1, 32'h444, 32'h12345678, 1, 1, st, rd_v);
    check("rdwr_stall", st, 32'd0);
    access(1'b1, 1'b0, 32'h444, 32'h0, 1, 1, st, rd_v);
    check("rdwr_is_store", rd_v, 32'h12345678);

    // Reset in the middle of a refill.
    cpu_MemRead_i = 1'b1;
    cpu_addr_i    = 32'h860;
    drf = 10;
    tick();
    tick();
    #1;
    check("pre_reset_refill_en", {31'b0, mem_enable_o}, 32'd1);
    rst_i = 1'b1;
    cpu_MemRead_i = 1'b0;
    #1;
    check("reset_drops_enable", {31'b0, mem_enable_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("post_reset_enable", {31'b0, mem_enable_o}, 32'd0);
    check("post_reset_stall", {31'b0, cpu_stall_o}, 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1, 1, st, rd_v);
    check("post_reset_miss_stall", st, 32'd3);
    check("post_reset_wb_data", rd_v, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h444, 32'h0, 1, 1, st, rd_v);
    check("dirty_discarded_stall", st, 32'd3);
    check("dirty_discarded_data", rd_v, init_word(32'h440, 1));

    // Random traffic over a few conflicting lines against the reference model.
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    gold.delete();
    for (int i = 0; i < 32; i++) begin
      mval[i] = 1'b0;
      mdirty[i] = 1'b0;
      mline[i] = '0;
    end
    begin
      int n_hit, n_miss;
      n_hit = 0;
      n_miss = 0;
      for (int n = 0; n < 300; n++) begin
        logic [31:0] a, d, la;
        int idx, op, dw_r, dr_r, exp_st;
        bit hit_m;
        idx  = $urandom_range(0, 3);
        a    = ($urandom_range(0, 3) << 10) | (idx << 5) | ($urandom_range(0, 7) << 2);
        la   = {a[31:5], 5'b0};
        op   = $urandom_range(0, 2);
        d    = $urandom;
        dw_r = $urandom_range(1, 4);
        dr_r = $urandom_range(1, 4);
        hit_m  = mval[idx] && (mline[idx] == la);
        exp_st = hit_m ? 0 : ((mval[idx] && mdirty[idx]) ? 2 + dw_r + dr_r : 2 + dr_r);
        access(op != 1, op != 0, a, d, dw_r, dr_r, st, rd_v);
        check($sformatf("rand%0d_stall", n), st, exp_st);
        if (op == 0) check($sformatf("rand%0d_data", n), rd_v, gold_word(a));
        if (!hit_m) begin
          mline[idx]  = la;
          mval[idx]   = 1'b1;
          mdirty[idx] = 1'b0;
          n_miss++;
        end
        n_hit++;
        if (op != 0) begin
          gold[a]     = d;
          mdirty[idx] = 1'b1;
        end
      end
`ifdef DCACHE_STATS_EN
      exp_h = n_hit; exp_m = n_miss;
`else
      exp_h = 32'd0; exp_m = 32'd0;
`endif
      #1;
      check("rand_hit_cnt", hit_cnt_o, exp_h);
      check("rand_miss_cnt", miss_cnt_o, exp_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
